// File: rtl/config_packet_serializer_pkg.sv
// Shared definitions for the config-net packet serializer.
//   config_s            : {cfg_clk, cfg_bit} bundle driven onto the config net
//   config_ser_state_e  : serializer FSM states
//   StartBit / IdleBit / FrameBit : line levels used for framing
//   max_of              : elaboration helper for counter sizing
package config_packet_serializer_pkg;

    typedef struct packed {
        logic cfg_clk;
        logic cfg_bit;
    } config_s;

    typedef enum logic [2:0] {
        StInit,
        StIdle,
        StStart,
        StId,
        StData,
        StFrame,
        StParity,
        StGap
    } config_ser_state_e;

    localparam logic StartBit = 1'b0;
    localparam logic IdleBit  = 1'b1;
    localparam logic FrameBit = 1'b1;

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/config_packet_serializer_if.sv
// Packet handshake + config-net output bundle for config_packet_serializer.
//   v_i / id_i / data_i : packet offered by the host (master drives)
//   ready_o             : serializer accepts a packet this cycle
//   config_o            : {cfg_clk, cfg_bit} toward the config_net node chain
//   busy_o              : serializer is not idle
// Modports: master (host side), slave (serializer side).
interface config_packet_serializer_if
    import config_packet_serializer_pkg::*;
#(
    parameter int unsigned id_width_p   = 8,
    parameter int unsigned data_width_p = 32
);

    logic                    v_i;
    logic [id_width_p-1:0]   id_i;
    logic [data_width_p-1:0] data_i;
    logic                    ready_o;
    config_s                 config_o;
    logic                    busy_o;

    modport master (
        output v_i,
        output id_i,
        output data_i,
        input  ready_o,
        input  config_o,
        input  busy_o
    );

    modport slave (
        input  v_i,
        input  id_i,
        input  data_i,
        output ready_o,
        output config_o,
        output busy_o
    );

endinterface

// File: rtl/config_ser_shift_reg.sv
// Loadable LSB-first shift register holding the packet shadow copy.
//   clk_i, reset_i : clock, asynchronous active-high reset (clears to zero)
//   load_i         : capture data_i (has priority over shift_i)
//   shift_i        : shift right by one, zero filled
//   data_i         : parallel load value
//   lsb_o          : current bit 0, i.e. the next bit to serialise
module config_ser_shift_reg #(
    parameter int unsigned width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               shift_i,
    input  logic [width_p-1:0] data_i,
    output logic               lsb_o
);

    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = data_i;
        end else if (shift_i) begin
            data_d = data_q >> 1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign lsb_o = data_q[0];

endmodule

// File: rtl/config_packet_serializer.sv
// Config-net driver: accepts {id,data} packets over valid/ready and serialises each onto
// config_o.cfg_bit as: start bit (0), id LSB first, payload in frames of frame_len_p bits
// (LSB first) each followed by a '1' framing bit, optional parity bit, gap_p '1' cycles.
// After reset the line is held at '1' for init_ones_p cycles before the first ready.
// Ports:
//   clk_i   : clock, also forwarded combinationally as config_o.cfg_clk
//   reset_i : asynchronous active-high reset (aborts any packet, line back to '1' at once)
//   bus     : slave side of config_packet_serializer_if (v_i/id_i/data_i in,
//             ready_o/config_o/busy_o out)
// Build option: define CONFIG_PACKET_SERIALIZER_PARITY_EN to append an even-parity bit
// (XOR of all id and data bits) after the last framing bit.
module config_packet_serializer
    import config_packet_serializer_pkg::*;
#(
    parameter int unsigned id_width_p   = 8,
    parameter int unsigned data_width_p = 32,
    parameter int unsigned frame_len_p  = 8,
    parameter int unsigned init_ones_p  = 16,
    parameter int unsigned gap_p        = 2
) (
    input logic                       clk_i,
    input logic                       reset_i,
    config_packet_serializer_if.slave bus
);

    localparam int unsigned frames_lp   = data_width_p / frame_len_p;
    localparam int unsigned cnt_max_lp  = max_of(max_of(max_of(id_width_p, frame_len_p),
                                                        max_of(init_ones_p, gap_p)),
                                                 frames_lp);
    localparam int unsigned cnt_w_lp    = $clog2(cnt_max_lp + 1);
    localparam int unsigned shadow_w_lp = id_width_p + data_width_p;

    typedef logic [cnt_w_lp-1:0] cnt_t;

    localparam cnt_t init_last_lp  = cnt_t'(init_ones_p - 1);
    localparam cnt_t id_last_lp    = cnt_t'(id_width_p - 1);
    localparam cnt_t frame_last_lp = cnt_t'(frame_len_p - 1);
    localparam cnt_t frames_last_lp = cnt_t'(frames_lp - 1);
    // Only meaningful when gap_p > 0; the GAP state is bypassed otherwise.
    localparam cnt_t gap_last_lp   = cnt_t'(gap_p - 1);

    if (data_width_p % frame_len_p != 0) begin : g_frame_check
        $error("data_width_p must be a multiple of frame_len_p");
    end

    config_ser_state_e state_q, state_d;
    cnt_t              cnt_q, cnt_d;
    cnt_t              frame_q, frame_d;
    logic              cfg_bit_q, cfg_bit_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              load;
    logic              shift;
    logic              sr_lsb;
    config_ser_state_e after_payload;
    config_ser_state_e after_parity;

`ifdef CONFIG_PACKET_SERIALIZER_PARITY_EN
    logic parity_q, parity_d;
`endif

    config_ser_shift_reg #(
        .width_p (shadow_w_lp)
    ) u_shadow (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (load),
        .shift_i (shift),
        .data_i  ({bus.data_i, bus.id_i}),
        .lsb_o   (sr_lsb)
    );

    assign after_parity = (gap_p == 0) ? StIdle : StGap;
`ifdef CONFIG_PACKET_SERIALIZER_PARITY_EN
    assign after_payload = StParity;
`else
    assign after_payload = after_parity;
`endif

    // Next-state logic. state_q names what is on the line during the current cycle; the
    // registered cfg_bit for the next cycle is derived from state_d.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        load    = 1'b0;

        unique case (state_q)
            StInit: begin
                if (cnt_q == init_last_lp) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StIdle: begin
                if (bus.v_i && ready_q) begin
                    state_d = StStart;
                    load    = 1'b1;
                end
            end
            StStart: begin
                state_d = StId;
                cnt_d   = '0;
            end
            StId: begin
                if (cnt_q == id_last_lp) begin
                    state_d = StData;
                    cnt_d   = '0;
                    frame_d = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StData: begin
                if (cnt_q == frame_last_lp) begin
                    state_d = StFrame;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            StFrame: begin
                cnt_d = '0;
                if (frame_q == frames_last_lp) begin
                    state_d = after_payload;
                end else begin
                    state_d = StData;
                    frame_d = frame_q + cnt_t'(1);
                end
            end
            StParity: begin
                state_d = after_parity;
                cnt_d   = '0;
            end
            StGap: begin
                if (cnt_q == gap_last_lp) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + cnt_t'(1);
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase

        // Each shift advances the shadow so bit 0 is always the next id/data bit to send.
        shift = (state_d == StId) || (state_d == StData);

        case (state_d)
            StStart:      cfg_bit_d = StartBit;
            StId, StData: cfg_bit_d = sr_lsb;
            StFrame:      cfg_bit_d = FrameBit;
`ifdef CONFIG_PACKET_SERIALIZER_PARITY_EN
            StParity:     cfg_bit_d = parity_q;
`endif
            default:      cfg_bit_d = IdleBit;
        endcase

        ready_d = (state_d == StIdle);
        busy_d  = (state_d != StIdle);
    end

`ifdef CONFIG_PACKET_SERIALIZER_PARITY_EN
    // Even parity is fixed at capture time so later input changes cannot affect it.
    assign parity_d = load ? ^{bus.data_i, bus.id_i} : parity_q;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= StInit;
            cnt_q     <= '0;
            frame_q   <= '0;
            cfg_bit_q <= IdleBit;
            ready_q   <= 1'b0;
            busy_q    <= 1'b1;
`ifdef CONFIG_PACKET_SERIALIZER_PARITY_EN
            parity_q  <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            cfg_bit_q <= cfg_bit_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
`ifdef CONFIG_PACKET_SERIALIZER_PARITY_EN
            parity_q  <= parity_d;
`endif
        end
    end

    assign bus.ready_o         = ready_q;
    assign bus.busy_o          = busy_q;
    assign bus.config_o.cfg_clk = clk_i;
    assign bus.config_o.cfg_bit = cfg_bit_q;

endmodule
